// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC generation and instruction request stage feeding IF/ID
//
// Keeps at most one instruction request outstanding on an SRAM-like port
// (req/addr_ok/data_ok). Returned instructions are registered and presented
// to IF/ID as {pc_o, inst_o, inst_valid_o}. Flush and taken branches redirect
// the PC. A response that belongs to a squashed request is swallowed in DISCARD.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush, flush_pc_i            pipeline flush and its target (highest priority)
//   branch_flag_i, branch_target_i  taken branch and its target
//   stall                        IF/ID cannot accept; hold presented instruction
//   inst_req_o, inst_addr_o      request valid and address
//   inst_addr_ok_i               address accepted this cycle
//   inst_data_ok_i, inst_rdata_i read data returned this cycle
//   pc_o, inst_o, inst_valid_o   presented instruction

module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  stall,
  output logic                  inst_req_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_addr_ok_i,
  input  logic                  inst_data_ok_i,
  input  logic [DATA_WIDTH-1:0] inst_rdata_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  req_issue;

  // Flush outranks a branch resolved in the same cycle.
  assign redirect    = flush | branch_flag_i;
  assign redirect_pc = flush ? flush_pc_i : branch_target_i;

  // No request goes out while a valid instruction is still stalled at the
  // output, so a response can never land on top of an unconsumed one.
  assign req_issue   = (state_q == S_REQ) && !(valid_q && stall);

  assign inst_req_o   = req_issue;
  assign inst_addr_o  = pc_q;
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    // The presented instruction is consumed on any unstalled cycle.
    valid_d  = stall ? valid_q : 1'b0;

    if (redirect) begin
      pc_d     = redirect_pc;
      pc_out_d = '0;
      inst_d   = '0;
      valid_d  = 1'b0;
      unique case (state_q)
        S_IDLE:    state_d = S_REQ;
        S_REQ:     state_d = (req_issue && inst_addr_ok_i) ? S_DISCARD : S_REQ;
        S_WAIT:    state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
        S_HOLD:    state_d = S_REQ;
        S_DISCARD: state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (req_issue && inst_addr_ok_i) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok_i) begin
            pc_out_d = pc_q;
            inst_d   = inst_rdata_i;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = stall ? S_HOLD : S_REQ;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (inst_data_ok_i) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with memory model and scoreboard

module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] MASK     = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        stall;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .flush_pc_i      (flush_pc),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .stall           (stall),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_addr_ok_i  (inst_addr_ok),
    .inst_data_ok_i  (inst_data_ok),
    .inst_rdata_i    (inst_rdata),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory model state
  bit          accept_en;
  int          mem_lat;
  bit          pending;
  bit          live;
  logic [31:0] pend_addr;
  int          lat_cnt;
  bit          acc_evt;
  logic [31:0] acc_addr;

  // scoreboard: {pc, inst} of every response that must reach the output
  logic [63:0] sb[$];
  int          pres_cnt;
  int          valid_cycles;
  bit          last_valid;

  task automatic cycle();
    bit          drv_aok;
    bit          drv_dok;
    bit          redir;
    bit          stall_edge;
    logic [31:0] req_addr;
    logic [63:0] exp;
    #1;
    drv_aok      = inst_req_o && accept_en && !rst;
    drv_dok      = pending && (lat_cnt == 0) && !rst;
    inst_addr_ok = drv_aok;
    inst_data_ok = drv_dok;
    inst_rdata   = drv_dok ? (pend_addr ^ MASK) : 32'h0;
    req_addr     = inst_addr_o;
    redir        = flush || branch_flag;
    stall_edge   = stall;
    @(posedge clk);
    #1;
    acc_evt = 1'b0;
    if (rst) begin
      pending = 1'b0;
      live    = 1'b0;
    end else begin
      if (drv_dok) begin
        if (live && !redir) sb.push_back({pend_addr, pend_addr ^ MASK});
        pending = 1'b0;
        live    = 1'b0;
      end else if (pending) begin
        lat_cnt--;
        if (redir) live = 1'b0;
      end
      if (drv_aok) begin
        pending   = 1'b1;
        live      = !redir;
        pend_addr = req_addr;
        lat_cnt   = mem_lat - 1;
        acc_evt   = 1'b1;
        acc_addr  = req_addr;
      end
    end
    if (!rst && inst_valid_o) begin
      valid_cycles++;
      if (!(last_valid && stall_edge)) begin
        pres_cnt++;
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got pc=%h inst=%h, required no output", pc_o, inst_o);
        end else begin
          exp = sb.pop_front();
          if ({pc_o, inst_o} !== exp)
            $display("FAIL sb_output: got pc=%h inst=%h, required pc=%h inst=%h",
                     pc_o, inst_o, exp[63:32], exp[31:0]);
          else
            pass_cnt++;
        end
      end
    end
    last_valid   = inst_valid_o;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
    flush_pc = 32'h0; branch_target = 32'h0;
    accept_en = 1'b1; mem_lat = 1;
    cycle();
    cycle();
    sb.delete();
    pres_cnt = 0; valid_cycles = 0; last_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_next_accept(output bit ok, output logic [31:0] a);
    ok = 1'b0;
    a  = 32'hx;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc_evt) begin
        ok = 1'b1;
        a  = acc_addr;
        break;
      end
    end
  endtask

  task automatic wait_accept_of(input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (acc_evt && acc_addr == addr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pres(output bit ok);
    int start;
    start = pres_cnt;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (pres_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (inst_req_o !== 1'b0) $display("FAIL reset_req: got %b, required 0", inst_req_o);
    else pass_cnt++;
    total_cnt++;
    if (inst_addr_o !== RESET_PC) $display("FAIL reset_addr: got %h, required %h", inst_addr_o, RESET_PC);
    else pass_cnt++;
    total_cnt++;
    if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h, required 0", pc_o);
    else pass_cnt++;
    total_cnt++;
    if (inst_o !== 32'h0) $display("FAIL reset_inst: got %h, required 0", inst_o);
    else pass_cnt++;
    total_cnt++;
    if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b, required 0", inst_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    bit          ok;
    logic [31:0] a;
    do_reset();
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== RESET_PC) $display("FAIL stream_first_addr: got %h ok=%b, required %h", a, ok, RESET_PC);
    else pass_cnt++;
    for (int i = 0; i < 40 && pres_cnt < 3; i++) cycle();
    total_cnt++;
    if (pres_cnt != 3 || pc_o !== 32'h1c000008)
      $display("FAIL stream_third: got count=%0d pc=%h, required count=3 pc=1c000008", pres_cnt, pc_o);
    else pass_cnt++;
    total_cnt++;
    if (valid_cycles != 3) $display("FAIL stream_pulse: got %0d valid cycles, required 3", valid_cycles);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] a;
    do_reset();
    wait_accept_of(32'h1c000004, ok);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total_cnt++;
      if (!ok || inst_valid_o !== 1'b1) $display("FAIL stall_valid[%0d]: got %b, required 1", i, inst_valid_o);
      else pass_cnt++;
      total_cnt++;
      if (pc_o !== 32'h1c000004) $display("FAIL stall_pc[%0d]: got %h, required 1c000004", i, pc_o);
      else pass_cnt++;
      total_cnt++;
      if (inst_o !== (32'h1c000004 ^ MASK)) $display("FAIL stall_inst[%0d]: got %h, required %h", i, inst_o, 32'h1c000004 ^ MASK);
      else pass_cnt++;
      total_cnt++;
      if (inst_req_o !== 1'b0) $display("FAIL stall_req[%0d]: got %b, required 0", i, inst_req_o);
      else pass_cnt++;
    end
    stall = 1'b0;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'h1c000008) $display("FAIL stall_next_addr: got %h ok=%b, required 1c000008", a, ok);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    bit          ok;
    logic [31:0] a;
    do_reset();
    mem_lat = 3;
    wait_accept_of(32'h1c000008, ok);
    branch_flag = 1'b1; branch_target = 32'h1c000100;
    cycle();
    branch_flag = 1'b0;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'h1c000100) $display("FAIL branch_addr: got %h ok=%b, required 1c000100", a, ok);
    else pass_cnt++;
    wait_pres(ok);
    total_cnt++;
    if (!ok || pc_o !== 32'h1c000100) $display("FAIL branch_first_pc: got %h ok=%b, required 1c000100", pc_o, ok);
    else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    bit          ok;
    logic [31:0] a;
    do_reset();
    wait_accept_of(32'h1c000004, ok);
    flush = 1'b1; flush_pc = 32'h1c008000;
    branch_flag = 1'b1; branch_target = 32'h1c000200;
    cycle();
    flush = 1'b0; branch_flag = 1'b0;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'h1c008000) $display("FAIL flush_prio_addr: got %h ok=%b, required 1c008000", a, ok);
    else pass_cnt++;
  endtask

  task automatic test_double_redirect();
    bit          ok;
    logic [31:0] a;
    do_reset();
    mem_lat = 4;
    wait_accept_of(RESET_PC, ok);
    branch_flag = 1'b1; branch_target = 32'h1c000200;
    cycle();
    branch_target = 32'h1c000300;
    cycle();
    branch_flag = 1'b0;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'h1c000300) $display("FAIL double_redirect_addr: got %h ok=%b, required 1c000300", a, ok);
    else pass_cnt++;
  endtask

  task automatic test_addr_ok_low();
    bit          ok;
    logic [31:0] a;
    do_reset();
    accept_en = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (inst_req_o !== 1'b1) $display("FAIL aok_low_req[%0d]: got %b, required 1", i, inst_req_o);
      else pass_cnt++;
      total_cnt++;
      if (inst_addr_o !== RESET_PC) $display("FAIL aok_low_addr[%0d]: got %h, required %h", i, inst_addr_o, RESET_PC);
      else pass_cnt++;
      cycle();
    end
    accept_en = 1'b1;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== RESET_PC) $display("FAIL aok_low_accept: got %h ok=%b, required %h", a, ok, RESET_PC);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit          ok;
    logic [31:0] a;
    do_reset();
    accept_en = 1'b0;
    cycle();
    branch_flag = 1'b1; branch_target = 32'hfffffffc;
    cycle();
    branch_flag = 1'b0;
    accept_en = 1'b1;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'hfffffffc) $display("FAIL wrap_first: got %h ok=%b, required fffffffc", a, ok);
    else pass_cnt++;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== 32'h0) $display("FAIL wrap_next: got %h ok=%b, required 00000000", a, ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    bit          ok;
    logic [31:0] a;
    do_reset();
    mem_lat = 4;
    wait_accept_of(RESET_PC, ok);
    rst = 1'b1;
    cycle();
    total_cnt++;
    if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0)
      $display("FAIL rst_mid_ctrl: got req=%b valid=%b, required 0 0", inst_req_o, inst_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (pc_o !== 32'h0 || inst_o !== 32'h0)
      $display("FAIL rst_mid_data: got pc=%h inst=%h, required 0 0", pc_o, inst_o);
    else pass_cnt++;
    total_cnt++;
    if (inst_addr_o !== RESET_PC) $display("FAIL rst_mid_addr: got %h, required %h", inst_addr_o, RESET_PC);
    else pass_cnt++;
    rst = 1'b0;
    mem_lat = 1;
    wait_next_accept(ok, a);
    total_cnt++;
    if (!ok || a !== RESET_PC) $display("FAIL rst_mid_resume: got %h ok=%b, required %h", a, ok, RESET_PC);
    else pass_cnt++;
    wait_pres(ok);
    total_cnt++;
    if (!ok || pc_o !== RESET_PC) $display("FAIL rst_mid_output: got %h ok=%b, required %h", pc_o, ok, RESET_PC);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; branch_flag = 1'b0; stall = 1'b0;
    flush_pc = 32'h0; branch_target = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    accept_en = 1'b1; mem_lat = 1; pending = 1'b0; live = 1'b0;
    pend_addr = 32'h0; lat_cnt = 0; acc_evt = 1'b0; acc_addr = 32'h0;
    pres_cnt = 0; valid_cycles = 0; last_valid = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_flush_priority();
    test_double_redirect();
    test_addr_ok_low();
    test_wrap();
    test_reset_mid_wait();

    for (int i = 0; i < 10; i++) cycle();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
